// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scancode receiver.
// Optional feature macro: PS2_PARITY_CHECK_EN enables the odd-parity check.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
   localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

   // start + 8 data + parity + stop
   localparam int PS2_FRAME_LEN = 11;

   localparam int PS2_TIMEOUT_W = 17;

   // True when data bits plus parity bit hold an odd number of ones
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 clock pin: 2-FF synchronizer, a FILTER_LEN-sample
// glitch filter, and a one-cycle strobe on a filtered 1->0 transition.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic resetn,
   input  logic raw,
   output logic fall
);

   logic [1:0] sync_q;
   logic       level_q;
   logic [7:0] cnt_q;

   // Synchronize, then only follow the new level after FILTER_LEN differing samples
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_q  <= 2'b11;
         level_q <= 1'b1;
         cnt_q   <= 8'd0;
         fall    <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw};
         fall   <= 1'b0;
         if (sync_q[1] == level_q) begin
            cnt_q <= 8'd0;
         end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
            level_q <= sync_q[1];
            cnt_q   <= 8'd0;
            fall    <= level_q;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard front end: frames 11-bit packets, strips the E0/F0 prefixes
// and emits one qualified scancode event per make or break.
// Optional feature macro: PS2_PARITY_CHECK_EN (odd parity enforced when defined).
module ps2_scancode_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       PS2Clk,
   input  logic       PS2Dat,
   output logic [7:0] ScanCode,
   output logic       IsBreak,
   output logic       IsExtended,
   output logic       CodeValid,
   output logic       FrameError,
   output logic       Busy
);

   localparam logic [2:0]               LAST_BIT    = 3'(PS2_FRAME_LEN - 4);
   localparam logic [PS2_TIMEOUT_W-1:0] TIMEOUT_LIM = PS2_TIMEOUT_W'(TIMEOUT_CYCLES);

   ps2_state_t                 state;
   logic [1:0]                 dat_sync;
   logic                       fall;
   logic                       dat;
   logic [2:0]                 bit_cnt;
   logic [7:0]                 shift;
   logic [PS2_TIMEOUT_W-1:0]   tcnt;
   logic                       ext_pending;
   logic                       brk_pending;
   logic                       parity_ok;

   ps2_line_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_clk_filter (
      .clock (Clock),
      .resetn(Resetn),
      .raw   (PS2Clk),
      .fall  (fall)
   );

   assign dat  = dat_sync[1];
   assign Busy = (state != ST_IDLE);

`ifdef PS2_PARITY_CHECK_EN
   logic parity_bit;
   assign parity_ok = odd_parity_ok(shift, parity_bit);
`else
   assign parity_ok = 1'b1;
`endif

   // Bring the data pin into the clock domain
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         dat_sync <= 2'b11;
      end else begin
         dat_sync <= {dat_sync[0], PS2Dat};
      end
   end

   // Inter-edge watchdog; a fall edge always restarts it
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tcnt <= '0;
      end else if (fall || state == ST_IDLE) begin
         tcnt <= '0;
      end else if (tcnt != TIMEOUT_LIM) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // Frame FSM, prefix tracking and registered event outputs
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state       <= ST_IDLE;
         bit_cnt     <= 3'd0;
         shift       <= 8'd0;
         ext_pending <= 1'b0;
         brk_pending <= 1'b0;
         ScanCode    <= 8'd0;
         IsBreak     <= 1'b0;
         IsExtended  <= 1'b0;
         CodeValid   <= 1'b0;
         FrameError  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         parity_bit  <= 1'b0;
`endif
      end else begin
         CodeValid  <= 1'b0;
         FrameError <= 1'b0;
         if (fall) begin
            case (state)
               ST_IDLE: begin
                  if (!dat) begin
                     state   <= ST_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift   <= {dat, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == LAST_BIT) begin
                     state <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  parity_bit <= dat;
`endif
                  state <= ST_STOP;
               end
               ST_STOP: begin
                  state <= ST_IDLE;
                  if (!dat || !parity_ok) begin
                     FrameError  <= 1'b1;
                     ext_pending <= 1'b0;
                     brk_pending <= 1'b0;
                  end else if (shift == PS2_PREFIX_EXT) begin
                     ext_pending <= 1'b1;
                  end else if (shift == PS2_PREFIX_BREAK) begin
                     brk_pending <= 1'b1;
                  end else begin
                     ScanCode    <= shift;
                     IsBreak     <= brk_pending;
                     IsExtended  <= ext_pending;
                     CodeValid   <= 1'b1;
                     ext_pending <= 1'b0;
                     brk_pending <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE && tcnt == TIMEOUT_LIM) begin
            state       <= ST_IDLE;
            FrameError  <= 1'b1;
            ext_pending <= 1'b0;
            brk_pending <= 1'b0;
         end
      end
   end

endmodule
